// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, fetch FSM state type and default reset PC.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/npc_logic.sv
// Combinational next-PC selection: jump, taken beq, or sequential PC+4.
module npc_logic (
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] npc
);

    logic [31:0] jump_target;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;

    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
    // Plain 32-bit add wraps modulo 2^32, which is the intended PC behaviour.
    assign branch_target = pc_plus4 + branch_offset;

    always_comb begin
        npc = pc_plus4;
        if (jump) begin
            npc = jump_target;
        end else if (branch && zero) begin
            npc = branch_target;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Two-state instruction fetch unit (S_FETCH/S_EXEC) with next-PC selection.
// Optional ack-timeout error flag is built only when IF_TIMEOUT_EN is defined.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          ACK_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Stall_i,
    output logic [31:0] Instr_o,
    output logic [5:0]  OP_Code,
    output logic [31:0] PC_o,
    output logic [31:0] PC_Plus4_o,
    output logic        Instr_Valid,
    output logic        Fetch_Err
);

    if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_timeout
        $error("ACK_TIMEOUT must lie in 1..255 to fit the 8-bit counter");
    end

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  instr_reg, instr_next;
    logic [31:0]  pc_plus4;
    logic [31:0]  npc;

    assign pc_plus4 = pc_reg + 32'd4;

    npc_logic u_npc (
        .pc_plus4 (pc_plus4),
        .instr    (instr_reg),
        .jump     (Jump),
        .branch   (Branch),
        .zero     (Zero),
        .npc      (npc)
    );

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        case (state_reg)
            S_FETCH: begin
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!Stall_i) begin
                    pc_next    = npc;
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
            pc_reg    <= RESET_PC;
            instr_reg <= 32'h0000_0000;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
        end
    end

    // Gating with rst_n keeps the request low during reset even though the state is S_FETCH.
    assign imem_req    = rst_n && (state_reg == S_FETCH);
    assign imem_addr   = pc_reg;
    assign Instr_Valid = (state_reg == S_EXEC);
    assign Instr_o     = instr_reg;
    assign OP_Code     = instr_reg[31:26];
    assign PC_o        = pc_reg;
    assign PC_Plus4_o  = pc_plus4;

`ifdef IF_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(ACK_TIMEOUT);

    logic [7:0] to_cnt_reg, to_cnt_next;
    logic       fetch_err_reg, fetch_err_next;

    always_comb begin
        to_cnt_next    = to_cnt_reg;
        fetch_err_next = fetch_err_reg;
        if (state_reg == S_FETCH) begin
            if (imem_ack) begin
                to_cnt_next = 8'd0;
            end else if (to_cnt_reg != 8'hFF) begin
                to_cnt_next = to_cnt_reg + 8'd1;
            end
            // Sticky: only reset clears it; the fetch keeps waiting regardless.
            if (to_cnt_next >= TO_LIMIT) begin
                fetch_err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_reg    <= 8'd0;
            fetch_err_reg <= 1'b0;
        end else begin
            to_cnt_reg    <= to_cnt_next;
            fetch_err_reg <= fetch_err_next;
        end
    end

    assign Fetch_Err = fetch_err_reg;
`else
    assign Fetch_Err = 1'b0;
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL provide parameter ACK_TIMEOUT, default 15, maximum wait cycles for imem_ack before Fetch_Err asserts.
REQ-003 SHALL provide port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide ports imem_req  output  1  fetch request, and imem_addr  output  32  fetch address.
REQ-006 SHALL provide ports imem_ack  input  1  read data valid, and imem_rdata  input  32  instruction word.
REQ-007 SHALL provide ports Jump, Branch and Zero, each input 1: decoded jump, decoded beq, and ALU zero.
REQ-008 SHALL provide port Stall_i  input  1  holds the current instruction in execute.
REQ-009 SHALL provide ports Instr_o  output  32  latched instruction, and OP_Code  output  6  equal to Instr_o[31:26].
REQ-010 SHALL provide ports PC_o  output  32  address of Instr_o, and PC_Plus4_o  output  32  PC_o+4.
REQ-011 SHALL provide ports Instr_Valid  output  1  execute cycle, and Fetch_Err  output  1  sticky timeout flag.

Function
REQ-012 SHALL implement a two-state FSM, S_FETCH and S_EXEC, entering S_FETCH on reset.
REQ-013 In S_FETCH the block SHALL drive imem_req=1 and imem_addr=PC_o, holding both stable until imem_ack.
REQ-014 On imem_ack in S_FETCH the block SHALL latch imem_rdata into Instr_o and move to S_EXEC on the next edge.
REQ-015 In S_EXEC the block SHALL drive Instr_Valid=1 and imem_req=0, and SHALL ignore imem_ack.
REQ-016 In S_EXEC with Stall_i=1 the block SHALL hold state, PC_o and Instr_o unchanged.
REQ-017 In S_EXEC with Stall_i=0 the block SHALL load PC_o with the next PC and return to S_FETCH, giving one S_EXEC cycle per unstalled instruction.
REQ-018 Next PC SHALL be, in priority order:
- Jump=1: {PC_Plus4_o[31:28], Instr_o[25:0], 2'b00}
- Branch=1 and Zero=1: PC_Plus4_o + (signext(Instr_o[15:0]) << 2)
- otherwise: PC_Plus4_o
REQ-019 All PC arithmetic SHALL be 32-bit modulo 2^32, so 32'hFFFF_FFFC+4 SHALL produce 0.
REQ-020 Stall_i SHALL be ignored in S_FETCH, and Jump, Branch and Zero SHALL be sampled only in the S_EXEC exit cycle.
REQ-021 Minimum latency, imem_req rising to Instr_Valid, SHALL be 2 cycles with a same-cycle ack.

Reset
REQ-022 rst_n=0 SHALL asynchronously force:
- PC_o=RESET_PC
- Instr_o=0
- Instr_Valid=0
- Fetch_Err=0
- state S_FETCH
- timeout counter 0
REQ-023 imem_req SHALL be 0 while rst_n=0, and SHALL be 1 in the first cycle after release.
REQ-024 Reset during an outstanding request SHALL abandon that request, and a late imem_ack SHALL be ignored until S_FETCH is re-entered.

Configuration
REQ-025 With IF_TIMEOUT_EN defined, an 8-bit counter SHALL count S_FETCH cycles without ack, clear on ack, and set Fetch_Err when it reaches ACK_TIMEOUT.
REQ-026 Fetch_Err SHALL remain set until reset, and the fetch SHALL continue waiting after Fetch_Err sets.
REQ-027 Without IF_TIMEOUT_EN, the Fetch_Err port SHALL exist, be tied to 0, and no counter SHALL be built.

Structure
REQ-028 The shared package cpu_pkg SHALL hold:
- opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_ADDI=6'b001000, OP_BEQ=6'b000100, OP_J=6'b000010
- the fetch state enum
- the default RESET_PC
REQ-029 Next-PC selection SHALL be a combinational sub-module npc_logic, instantiated once.

Verification
REQ-030 Reset then ack every cycle, no branches -> imem_addr SHALL be 0, 4, 8 on successive S_FETCH cycles, with Instr_Valid one cycle in two.
REQ-031 Instr_o=32'h1000_FFFF (beq, offset -1) at PC 0x40 with Branch=1 and Zero=1 -> next imem_addr SHALL be 0x40; with Zero=0 it SHALL be 0x44.
REQ-032 Instr_o=32'h0800_0010 at PC 0x1000 with Jump=1 and Branch=1 -> next imem_addr SHALL be 0x40.
REQ-033 Stall_i=1 for 3 cycles in S_EXEC -> Instr_Valid SHALL stay 1 for 4 cycles and PC_o SHALL stay unchanged.
REQ-034 PC_o=32'hFFFF_FFFC, sequential -> next imem_addr SHALL be 0.
REQ-035 With IF_TIMEOUT_EN defined and no ack for 15 cycles -> Fetch_Err SHALL set and stay set after a later ack; rst_n pulsed mid-request -> imem_req SHALL drop immediately, then refetch from RESET_PC.
